// File: rtl/reg_file_if.sv
// Register file bus: two combinational read ports, one write port and the PC alias input.
interface reg_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [ADDR_WIDTH-1:0] addr_2;
    logic [ADDR_WIDTH-1:0] addr_3;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] r15;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;

    // Datapath side: drives addresses, write data and the PC value.
    modport master (
        output write_en, addr_1, addr_2, addr_3, write_data, r15,
        input  read_data_1, read_data_2
    );

    // Register file side.
    modport slave (
        input  write_en, addr_1, addr_2, addr_3, write_data, r15,
        output read_data_1, read_data_2
    );
endinterface

// File: rtl/reg_file.sv
// ARM-style register file: entries 0..14 are flops, entry 15 aliases the
// externally supplied PC value. Reads are combinational with no write bypass.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned PC_INDEX = NUM_REGS - 1;

    logic [DATA_WIDTH-1:0] regs [PC_INDEX];
    logic [DATA_WIDTH-1:0] view [NUM_REGS];
    logic                  write_hit;

    // A write to the PC alias is dropped; it is never stored.
    assign write_hit = bus.write_en && (bus.addr_3 != ADDR_WIDTH'(PC_INDEX));

    // Storage: async clear, then one write per rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PC_INDEX; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[bus.addr_3] <= bus.write_data;
        end
    end

    // Full 16-entry read view with r15 substituted at the top index.
    always_comb begin
        for (int unsigned i = 0; i < PC_INDEX; i++) begin
            view[i] = regs[i];
        end
        view[PC_INDEX] = bus.r15;
    end

    assign bus.read_data_1 = view[bus.addr_1];
    assign bus.read_data_2 = view[bus.addr_2];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reset, table-driven vectors, hand-written
// corner sequences and a randomized phase against a small reference model.
module tb_reg_file;
    logic clk;
    logic rst;

    reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp_1;
        logic [31:0] exp_2;
    } sb_t;

    typedef struct {
        logic        we;
        logic [3:0]  a3;
        logic [31:0] wd;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [31:0] r15;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    localparam int NV = 15;

    sb_t         sb [$];
    vec_t        vecs [NV];
    logic [31:0] mdl [15];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs and queue the read values expected before the next edge.
    task automatic drive(input logic we, input logic [3:0] a3, input logic [31:0] wd,
                         input logic [3:0] a1, input logic [3:0] a2, input logic [31:0] r15v,
                         input logic [31:0] e1, input logic [31:0] e2, input string name);
        sb_t e;
        bus.write_en   = we;
        bus.addr_3     = a3;
        bus.write_data = wd;
        bus.addr_1     = a1;
        bus.addr_2     = a2;
        bus.r15        = r15v;
        e.name  = name;
        e.exp_1 = e1;
        e.exp_2 = e2;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare both read ports.
    task automatic sample();
        sb_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: empty queue, got %h/%h, want an entry",
                     bus.read_data_1, bus.read_data_2);
        end else begin
            e = sb.pop_front();
            cmp({e.name, ".rd1"}, bus.read_data_1, e.exp_1);
            cmp({e.name, ".rd2"}, bus.read_data_2, e.exp_2);
        end
    endtask

    initial begin
        // vectors: inputs applied mid-cycle, reads checked before the edge that writes
        vecs[0]  = '{1'b1, 4'd0,  32'h0000_01DA, 4'd0,  4'd1,  32'h0,  32'h0,          32'h0};
        vecs[1]  = '{1'b1, 4'd1,  32'h0000_FFFF, 4'd0,  4'd1,  32'h0,  32'h0000_01DA,  32'h0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,         4'd0,  4'd1,  32'h0,  32'h0000_01DA,  32'h0000_FFFF};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,         4'd0,  4'd0,  32'h0,  32'h0000_01DA,  32'h0000_01DA};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,         4'd0,  4'd1,  32'h0,  32'h0000_01DA,  32'h0000_FFFF};
        vecs[5]  = '{1'b1, 4'd10, 32'h0A00_D3F1, 4'd10, 4'd10, 32'h0,  32'h0,          32'h0};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,         4'd1,  4'd10, 32'h0,  32'h0000_FFFF,  32'h0A00_D3F1};
        vecs[7]  = '{1'b1, 4'd15, 32'hDEAD_BEEF, 4'd15, 4'd10, 32'h8,  32'h8,          32'h0A00_D3F1};
        vecs[8]  = '{1'b0, 4'd15, 32'h0,         4'd15, 4'd15, 32'h8,  32'h8,          32'h8};
        vecs[9]  = '{1'b1, 4'd14, 32'h8000_0001, 4'd14, 4'd15, 32'hC,  32'h0,          32'hC};
        vecs[10] = '{1'b0, 4'd0,  32'h0,         4'd14, 4'd0,  32'hC,  32'h8000_0001,  32'h0000_01DA};
        vecs[11] = '{1'b1, 4'd2,  32'hFFFF_FFFF, 4'd2,  4'd10, 32'h0,  32'h0,          32'h0A00_D3F1};
        vecs[12] = '{1'b0, 4'd0,  32'h0,         4'd2,  4'd14, 32'h0,  32'hFFFF_FFFF,  32'h8000_0001};
        vecs[13] = '{1'b1, 4'd10, 32'h1234_5678, 4'd10, 4'd10, 32'h0,  32'h0A00_D3F1,  32'h0A00_D3F1};
        vecs[14] = '{1'b0, 4'd0,  32'h0,         4'd10, 4'd1,  32'h0,  32'h1234_5678,  32'h0000_FFFF};

        // Reset phase: writes attempted while rst is low must be ignored.
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, "reset");
        void'(sb.pop_front());
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 4'd3, 32'hFFFF_FFFF, 4'd0, 4'd3, 32'h0, 32'h0, 32'h0, "reset_hold");
            #1 sample();
        end
        drive(1'b0, 4'd0, 32'h0, 4'd15, 4'd3, 32'h1234_5678, 32'h1234_5678, 32'h0, "reset_r15");
        #1 sample();
        bus.write_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].a1, vecs[i].a2,
                  vecs[i].r15, vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
            #1 sample();
        end

        // Outputs hold steady over 60 ns with writes disabled.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1'b0, 4'd1, 32'hAAAA_AAAA, 4'd1, 4'd10, 32'h0, 32'h0000_FFFF, 32'h1234_5678, "stable");
            #1 sample();
        end

        // r15 alias follows the input with no clock edge.
        @(negedge clk);
        drive(1'b1, 4'd15, 32'hDEAD_BEEF, 4'd15, 4'd1, 32'h8, 32'h8, 32'h0000_FFFF, "r15_pre");
        #1 sample();
        drive(1'b1, 4'd15, 32'hDEAD_BEEF, 4'd15, 4'd1, 32'hC, 32'hC, 32'h0000_FFFF, "r15_noclk");
        #1 sample();
        @(negedge clk);
        drive(1'b0, 4'd15, 32'h0, 4'd15, 4'd15, 32'hC, 32'hC, 32'hC, "r15_post");
        #1 sample();

        // Asynchronous reset between edges clears storage before the next edge.
        @(negedge clk);
        drive(1'b0, 4'd0, 32'h0, 4'd10, 4'd14, 32'h4, 32'h1234_5678, 32'h8000_0001, "arst_pre");
        #1 sample();
        #1 rst = 1'b0;
        drive(1'b1, 4'd10, 32'h0000_0055, 4'd10, 4'd15, 32'h4, 32'h0, 32'h4, "arst_now");
        #1 sample();
        repeat (2) @(negedge clk);
        drive(1'b1, 4'd10, 32'h0000_0055, 4'd10, 4'd14, 32'h4, 32'h0, 32'h0, "arst_write");
        #1 sample();
        bus.write_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'h0, 4'd10, 4'd2, 32'h4, 32'h0, 32'h0, "arst_release");
        #1 sample();

        // Randomized phase against a reference array (all zero after the reset above).
        for (int i = 0; i < 15; i++) mdl[i] = 32'h0;
        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic [3:0]  a1, a2, a3;
            logic [31:0] wd, rv, e1, e2;
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            a1 = 4'($urandom_range(0, 15));
            a2 = 4'($urandom_range(0, 15));
            a3 = 4'($urandom_range(0, 15));
            wd = $urandom;
            rv = $urandom;
            e1 = (a1 == 4'd15) ? rv : mdl[a1];
            e2 = (a2 == 4'd15) ? rv : mdl[a2];
            drive(we, a3, wd, a1, a2, rv, e1, e2, $sformatf("rand%0d", i));
            #1 sample();
            if (we && a3 != 4'd15) mdl[a3] = wd;
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
